// File: rtl/bp_fe_instr_realigner.sv
// bp_fe_instr_realigner: halfword realignment buffer splitting fetch parcels into RVC/full instructions
// RVC support is enabled by defining BP_FE_REALIGNER_COMPRESSED_EN; otherwise every instruction is full-width.
module bp_fe_instr_realigner #(
  parameter int vaddr_width_p = 39,
  parameter int buf_els_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     fetch_v_i,
  input  logic [vaddr_width_p-1:0] fetch_pc_i,
  input  logic [31:0]              fetch_data_i,
  output logic                     fetch_ready_and_o,
  output logic                     instr_v_o,
  output logic [vaddr_width_p-1:0] instr_pc_o,
  output logic [31:0]              instr_o,
  output logic                     instr_compressed_o,
  input  logic                     instr_yumi_i,
  output logic                     rebase_o
);
  localparam int vw = vaddr_width_p;
  localparam int pw = $clog2(buf_els_p);
  localparam int cw = $clog2(buf_els_p + 1);
  logic [15:0] mem_q [buf_els_p];
  logic [pw-1:0] rptr_q, wptr_q, wi;
  logic [cw-1:0] count_q, rem;
  logic [vw-1:0] pc_q, fpc, tail;
  logic [15:0] h0, h1;
  logic [1:0] pop_n, push_n;
  logic comp, half, push, restart, unused_pc;
  assign h0 = mem_q[rptr_q];
  assign h1 = mem_q[rptr_q + pw'(1)];
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
  assign comp = h0[1:0] != 2'b11;
  assign half = fetch_pc_i[1];
`else
  assign comp = 1'b0;
  assign half = 1'b0;
`endif
  assign unused_pc = ^fetch_pc_i[1:0];
  assign instr_v_o = ((count_q >= cw'(1)) & comp) | (count_q >= cw'(2));
  assign instr_o = comp ? {16'b0, h0} : {h1, h0};
  assign instr_compressed_o = comp;
  assign instr_pc_o = pc_q;
  assign fetch_ready_and_o = ~reset_i & ~flush_i & ((cw'(buf_els_p) - count_q) >= cw'(2));
  assign pop_n = (instr_yumi_i & instr_v_o) ? (comp ? 2'd1 : 2'd2) : 2'd0;
  assign push = fetch_v_i & fetch_ready_and_o;
  assign push_n = half ? 2'd1 : 2'd2;
  assign rem = count_q - cw'(pop_n);
  assign fpc = {fetch_pc_i[vw-1:2], half, 1'b0};
  assign tail = pc_q + {{(vw-cw-1){1'b0}}, count_q, 1'b0};
  // A parcel that does not continue the surviving residue replaces it outright.
  assign restart = push & ((rem == '0) | (fpc != tail));
  assign rebase_o = push & (rem != '0) & (fpc != tail);
  assign wi = restart ? '0 : wptr_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
      pc_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else if (flush_i) begin
      count_q <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
    end else if (restart) begin
      count_q <= cw'(push_n);
      rptr_q <= '0;
      wptr_q <= pw'(push_n);
      pc_q <= fpc;
    end else begin
      count_q <= rem + (push ? cw'(push_n) : '0);
      rptr_q <= rptr_q + pw'(pop_n);
      wptr_q <= wptr_q + (push ? pw'(push_n) : '0);
      pc_q <= pc_q + {{(vw-3){1'b0}}, pop_n, 1'b0};
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wi] <= half ? fetch_data_i[31:16] : fetch_data_i[15:0];
      if (!half) mem_q[wi + pw'(1)] <= fetch_data_i[31:16];
    end
  end
`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(instr_yumi_i & ~instr_v_o)) else $error("realigner: yumi without valid");
      assert (count_q <= cw'(buf_els_p)) else $error("realigner: count overflow");
    end
  end
`endif
endmodule

// File: tb/tb_bp_fe_instr_realigner.sv
// tb_bp_fe_instr_realigner: scoreboard bench with a halfword-stream reference model
module tb_bp_fe_instr_realigner;
  localparam int VW = 39;
  localparam int BUF = 4;
`ifdef BP_FE_REALIGNER_COMPRESSED_EN
  localparam bit CEN = 1'b1;
`else
  localparam bit CEN = 1'b0;
`endif
  logic clk = 1'b0, reset_i = 1'b1, flush_i = 1'b0, fetch_v_i = 1'b0, instr_yumi_i = 1'b0;
  logic [VW-1:0] fetch_pc_i = '0, instr_pc_o;
  logic [31:0] fetch_data_i = '0, instr_o;
  logic fetch_ready_and_o, instr_v_o, instr_compressed_o, rebase_o;
  always #5 clk = ~clk;
  bp_fe_instr_realigner #(.vaddr_width_p(VW), .buf_els_p(BUF)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .fetch_v_i(fetch_v_i), .fetch_pc_i(fetch_pc_i), .fetch_data_i(fetch_data_i),
    .fetch_ready_and_o(fetch_ready_and_o), .instr_v_o(instr_v_o), .instr_pc_o(instr_pc_o),
    .instr_o(instr_o), .instr_compressed_o(instr_compressed_o),
    .instr_yumi_i(instr_yumi_i), .rebase_o(rebase_o));
  typedef struct { logic [VW-1:0] pc; logic [15:0] d; } hw_t;
  typedef struct { logic [VW-1:0] pc; logic [31:0] ins; logic c; } ex_t;
  typedef struct { bit fv; logic [VW-1:0] pc; logic [31:0] d; bit yen; bit fl; } dir_t;
  hw_t hq[$];
  ex_t exp_q[$];
  bit exp_v, exp_rdy, exp_reb, chk_en, done, final_chk;
  int tests = 0, fails = 0;
  logic [VW-1:0] npc = 39'h1000;
  function automatic bit hcomp(logic [15:0] d);
    return CEN && d[1:0] != 2'b11;
  endfunction
  function automatic bit mvalid();
    return (hq.size() >= 1 && hcomp(hq[0].d)) || hq.size() >= 2;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask
  // One cycle: drive inputs after the edge and advance the model to what the next edge should do.
  task automatic step(input bit fv, input logic [VW-1:0] pc, input logic [31:0] d, input bit yen, input bit fl);
    logic [VW-1:0] epc;
    int n;
    @(posedge clk); #1;
    fetch_v_i = fv; fetch_pc_i = pc; fetch_data_i = d; flush_i = fl;
    exp_v = mvalid();
    exp_rdy = !fl && (BUF - hq.size() >= 2);
    instr_yumi_i = yen && exp_v;
    exp_reb = 1'b0;
    if (fl) hq.delete();
    else begin
      if (instr_yumi_i) begin
        n = hcomp(hq[0].d) ? 1 : 2;
        exp_q.push_back(ex_t'{pc: hq[0].pc, ins: (n == 1) ? {16'h0, hq[0].d} : {hq[1].d, hq[0].d}, c: n == 1});
        repeat (n) void'(hq.pop_front());
      end
      if (fv && exp_rdy) begin
        epc = CEN ? {pc[VW-1:1], 1'b0} : {pc[VW-1:2], 2'b0};
        if (hq.size() != 0 && epc != hq[$].pc + 39'd2) begin
          exp_reb = 1'b1;
          hq.delete();
        end
        if (CEN && pc[1]) begin
          hq.push_back(hw_t'{pc: epc, d: d[31:16]});
          npc = epc + 39'd2;
        end else begin
          hq.push_back(hw_t'{pc: epc, d: d[15:0]});
          hq.push_back(hw_t'{pc: epc + 39'd2, d: d[31:16]});
          npc = epc + 39'd4;
        end
      end
    end
    chk_en = 1'b1;
  endtask
  initial begin : monitor
    ex_t e;
    forever begin
      @(negedge clk);
      if (reset_i) begin
        chk("rst_ready", {63'd0, fetch_ready_and_o}, 64'd0);
        chk("rst_valid", {63'd0, instr_v_o}, 64'd0);
      end else if (chk_en) begin
        chk("valid", {63'd0, instr_v_o}, {63'd0, exp_v});
        chk("ready", {63'd0, fetch_ready_and_o}, {63'd0, exp_rdy});
        chk("rebase", {63'd0, rebase_o}, {63'd0, exp_reb});
        if (instr_v_o && instr_yumi_i && !flush_i) begin
          if (exp_q.size() == 0) chk("instr_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("instr_pc", 64'(instr_pc_o), 64'(e.pc));
            chk("instr", 64'(instr_o), 64'(e.ins));
            chk("compressed", {63'd0, instr_compressed_o}, {63'd0, e.c});
          end
        end
        if (done && !final_chk) begin
          final_chk = 1'b1;
          chk("drain", 64'(exp_q.size()), 64'd0);
        end
      end
    end
  end
  dir_t dir[$] = '{
    '{1, 39'h1000, 32'h00A00093, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h2000, 32'h45054501, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h3000, 32'h00934501, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h3004, 32'h123400A0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h4002, 32'h4505FFFF, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h3000, 32'h00934501, 0, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h5000, 32'h00A00093, 0, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0},
    '{1, 39'h6000, 32'h00A00093, 0, 0}, '{1, 39'h6004, 32'h00B00113, 0, 0},
    '{1, 39'h6008, 32'h00C00193, 0, 1}, '{0, 0, 0, 1, 0}, '{0, 0, 0, 1, 0}
  };
  initial begin : driver
    logic [VW-1:0] pc;
    logic [31:0] d;
    int r;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    foreach (dir[i]) step(dir[i].fv, dir[i].pc, dir[i].d, dir[i].yen, dir[i].fl);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom % 16);
      pc = (r == 0) ? {7'h0, 32'($urandom)} : (r == 1) ? 39'h7FFFFFFFFC : npc;
      if ($urandom % 2 == 1) pc[0] = 1'b1;
      if ($urandom % 8 == 0) pc[1] = ~pc[1];
      d = $urandom;
      if ($urandom % 2 == 1) d[1:0] = 2'b11;
      if ($urandom % 2 == 1) d[17:16] = 2'b11;
      step($urandom % 4 != 0, pc, d, $urandom % 4 != 0, $urandom % 40 == 0);
    end
    repeat (10) step(1'b0, '0, '0, 1'b1, 1'b0);
    done = 1'b1;
    repeat (2) @(negedge clk);
    #1 $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
